// File: rtl/spi_controller.sv
// SPI mode-0 initiator for 16-bit {R/W, addr[6:0], data[7:0]} frames, MSB first.
// Every SPI pin and status output is driven straight from a flop.
module spi_controller #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_GAP   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic [7:0] rsp_rdata,
  output logic       done,
  output logic       busy,
  output logic       sclk,
  output logic       ncs,
  output logic       copi,
  input  logic       cipo
);

  localparam int unsigned MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned MAX_CD = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int unsigned MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW     = (MAXP < 2) ? 1 : $clog2(MAXP);

  localparam logic [CW-1:0] DIV_M1   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_M1 = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_M1  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_M1   = CW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    HOLD,
    GAP
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     bit_q, bit_d;
  logic [15:0]    sh_q, sh_d;
  logic [7:0]     cap_q, cap_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           wr_q, wr_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           sclk_q, sclk_d;
  logic           ncs_q, ncs_d;
  logic           copi_q, copi_d;
  logic           cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          state_d = SETUP;
          cnt_d   = SETUP_M1;
          bit_d   = 4'd15;
          sh_d    = {req_write, req_addr, req_write ? req_wdata : 8'h00};
          wr_d    = req_write;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_d = SHIFT_LO;
          cnt_d   = DIV_M1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SHIFT_LO: begin
        if (cnt_zero) begin
          // cipo is sampled on the same edge that raises sclk
          state_d = SHIFT_HI;
          cnt_d   = DIV_M1;
          cap_d   = {cap_q[6:0], cipo};
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SHIFT_HI: begin
        if (cnt_zero) begin
          if (bit_q == 4'd0) begin
            state_d = HOLD;
            cnt_d   = HOLD_M1;
          end else begin
            state_d = SHIFT_LO;
            cnt_d   = DIV_M1;
            bit_d   = bit_q - 4'd1;
            sh_d    = {sh_q[14:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_d = GAP;
          cnt_d   = GAP_M1;
          done_d  = 1'b1;
          if (!wr_q) rdata_d = cap_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_zero) state_d = IDLE;
        else          cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Pin values are derived from the next state so they register alongside it
    ncs_d   = !(state_d inside {SETUP, SHIFT_LO, SHIFT_HI, HOLD});
    sclk_d  = (state_d == SHIFT_HI);
    copi_d  = (state_d inside {SETUP, SHIFT_LO, SHIFT_HI}) ? sh_d[15] : 1'b0;
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      copi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      copi_q  <= copi_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_rdata = rdata_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign sclk      = sclk_q;
  assign ncs       = ncs_q;
  assign copi      = copi_q;

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI mode-0 initiator that generates the 16-bit register-write frames consumed by spi_peripheral. The frame layout is {R/W, addr[6:0], data[7:0]}, MSB first. The block drives nCS/SCLK/COPI from a valid/ready request port. For read frames it captures the 8 returned data bits from CIPO. It is used in the bring-up harness and in integration tests that configure the output-enable, PWM-enable and duty-cycle registers.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; min 1; use >=4 when driving spi_peripheral, which oversamples SCLK through synchronisers
CS_SETUP, 2, clk cycles nCS low before first SCLK low phase; min 1
CS_HOLD, 2, clk cycles after last SCLK high phase before nCS rises; min 1
CS_GAP, 2, clk cycles nCS held high between frames; min 1

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset; asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1=write frame, 0=read frame
req_addr  in  7  register address
req_wdata  in  8  write data; ignored for reads
rsp_rdata  out  8  data captured by the last read frame
done  out  1  one-cycle pulse at frame end
busy  out  1  frame in progress (SETUP..GAP)
sclk  out  1  SPI clock, idle low
ncs  out  1  chip select, active low
copi  out  1  controller-out data
cipo  in  1  controller-in data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: ncs=1, sclk=0, copi=0, busy=0, done=0, rsp_rdata=0x00, req_ready=0 while rst is high, state IDLE.
- All SPI outputs come straight from flops (glitch-free).
- Handshake:
  - req_ready=1 only in IDLE.
  - A request is accepted on the clk edge where req_valid & req_ready.
  - At acceptance, shift reg = {req_write, req_addr, req_write ? req_wdata : 8'h00}.
  - Input changes after acceptance have no effect on the frame.
- States: IDLE -> SETUP -> SHIFT_LO -> SHIFT_HI -> (repeat LO/HI for 16 bits) -> HOLD -> GAP -> IDLE.
- SETUP: CS_SETUP cycles, starting the cycle after acceptance. ncs=0, sclk=0, copi=bit15, busy=1.
- SHIFT_LO(bit i): CLK_DIV cycles, sclk=0, copi=bit i. COPI changes only when entering SHIFT_LO.
- SHIFT_HI(bit i): CLK_DIV cycles, sclk=1.
  - On the clk edge that raises sclk, cipo is sampled into the capture reg, MSB first.
  - Only bits 7..0 are kept.
- A bit counter 15..0 decrements on leaving SHIFT_HI. After bit 0, go to HOLD.
- HOLD: CS_HOLD cycles, sclk=0, ncs=0, copi=0.
- GAP: CS_GAP cycles with ncs=1, busy=1.
  - done=1 in the first GAP cycle only.
  - If the frame was a read, rsp_rdata updates on the same edge.
  - If the frame was a write, rsp_rdata holds its old value.
- Frame timing:
  - ncs low for exactly CS_SETUP + 32*CLK_DIV + CS_HOLD cycles.
  - Exactly 16 sclk rising edges per frame.
  - Acceptance-to-done latency = CS_SETUP + 32*CLK_DIV + CS_HOLD + 1 cycles.
- Back-to-back: req_ready returns high the cycle after GAP ends, so min ncs-high time between frames = CS_GAP + 1 cycles.
- Reset mid-frame: outputs return immediately to reset values, the partial frame is dropped, and the capture reg is cleared.
- req_valid held high during busy is not accepted and is not queued.
- Timing counters are sized to hold max(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP); no wrap within a phase.

Test Plan:
1. Assert rst mid-sim without a clock edge -> ncs=1, sclk=0, copi=0, busy=0, done=0, rsp_rdata=0x00 immediately.
2. CLK_DIV=2, SETUP/HOLD/GAP=1; write addr 0x00 data 0xF0 -> COPI sampled at 16 sclk rises = 0x80F0; ncs low exactly 66 cycles; single done pulse 67 cycles after acceptance.
3. req_valid held high with two writes (0x02=0x0F, then 0x03=0xAA) -> req_ready low throughout frame 1; second frame starts only after ncs high >= 2 cycles; COPI words 0x820F then 0x83AA.
4. Read addr 0x10 with a CIPO model returning 0xA5 MSB-first -> COPI word 0x1000; rsp_rdata=0xA5 on the done cycle; a following write leaves rsp_rdata=0xA5.
5. Assert rst after the 5th sclk rise -> ncs=1, sclk=0 asynchronously. A new write 0x04=0x80 after release produces a complete, correct 0x8480 frame.
6. Integration, CLK_DIV=4, driving spi_peripheral: write 0x00=0xFF, 0x02=0xFF, 0x04=0x80 -> en_reg_out_7_0=0xFF, en_reg_pwm_7_0=0xFF, pwm_duty_cycle=0x80; uo_out toggles at 50% duty.
